// File: rtl/instr_loader.sv
// UART program loader: receives 8N1 bytes, assembles little-endian 32-bit words
// and streams them into instruction memory until the 0xFFFFFFFF terminator arrives.
module instr_loader #(
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        uart_rx,
   output logic [31:0] write_byte_address,
   output logic [31:0] write_instr_data,
   output logic        write_instr_valid,
   output logic        start,
   output logic        loading,
   output logic        frame_error
);

   localparam int unsigned CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned HALF_M1 = CLKS_PER_BIT / 2 - 1;
   localparam int unsigned FULL_M1 = CLKS_PER_BIT - 1;
   localparam logic [31:0] TERMINATOR = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_e;

   typedef enum logic {
      LD_LOAD,
      LD_RUN
   } ld_state_e;

   logic             rx_meta_q;
   logic             rx_sync_q;
   rx_state_e        rx_state_q;
   logic [CNT_W-1:0] clk_cnt_q;
   logic [2:0]       bit_cnt_q;
   logic [7:0]       shift_q;
   logic [7:0]       byte_q;
   logic             byte_valid_q;
   logic             frame_error_q;

   ld_state_e        ld_state_q;
   logic [1:0]       byte_idx_q;
   logic [31:0]      word_q;
   logic [31:0]      addr_q;
   logic [31:0]      wr_addr_q;
   logic [31:0]      wr_data_q;
   logic             wr_valid_q;
   logic             start_q;
   logic             loading_q;
   logic [31:0]      full_word;

   // Two-flop synchronizer; idles high so reset does not look like a start bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
      end else begin
         rx_meta_q <= uart_rx;
         rx_sync_q <= rx_meta_q;
      end
   end

   // Receiver FSM: mid-bit sampling, start-bit glitch rejection, stop-bit check.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_state_q    <= RX_IDLE;
         clk_cnt_q     <= '0;
         bit_cnt_q     <= '0;
         shift_q       <= '0;
         byte_q        <= '0;
         byte_valid_q  <= 1'b0;
         frame_error_q <= 1'b0;
      end else begin
         byte_valid_q <= 1'b0;
         unique case (rx_state_q)
            RX_IDLE: begin
               if (!rx_sync_q) begin
                  rx_state_q <= RX_START;
                  clk_cnt_q  <= '0;
                  bit_cnt_q  <= '0;
               end
            end
            RX_START: begin
               if (clk_cnt_q == CNT_W'(HALF_M1)) begin
                  clk_cnt_q  <= '0;
                  rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
               end else begin
                  clk_cnt_q <= clk_cnt_q + CNT_W'(1);
               end
            end
            RX_DATA: begin
               if (clk_cnt_q == CNT_W'(FULL_M1)) begin
                  clk_cnt_q <= '0;
                  shift_q   <= {rx_sync_q, shift_q[7:1]};
                  if (bit_cnt_q == 3'd7) begin
                     rx_state_q <= RX_STOP;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 3'd1;
                  end
               end else begin
                  clk_cnt_q <= clk_cnt_q + CNT_W'(1);
               end
            end
            RX_STOP: begin
               if (clk_cnt_q == CNT_W'(FULL_M1)) begin
                  clk_cnt_q  <= '0;
                  rx_state_q <= RX_IDLE;
                  if (rx_sync_q) begin
                     byte_q       <= shift_q;
                     byte_valid_q <= 1'b1;
                  end else begin
                     frame_error_q <= 1'b1;
                  end
               end else begin
                  clk_cnt_q <= clk_cnt_q + CNT_W'(1);
               end
            end
            default: rx_state_q <= RX_IDLE;
         endcase
      end
   end

   assign full_word = {byte_q, word_q[23:0]};

   // Loader FSM: packs bytes into lanes, strobes complete words, halts on terminator.
   always_ff @(posedge clk) begin
      if (rst) begin
         ld_state_q <= LD_LOAD;
         byte_idx_q <= '0;
         word_q     <= '0;
         addr_q     <= '0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         wr_valid_q <= 1'b0;
         start_q    <= 1'b0;
         loading_q  <= 1'b0;
      end else begin
         wr_valid_q <= 1'b0;
         start_q    <= (ld_state_q == LD_RUN);
         if (ld_state_q == LD_LOAD && byte_valid_q) begin
            if (byte_idx_q == 2'd3) begin
               wr_valid_q <= 1'b1;
               wr_data_q  <= full_word;
               wr_addr_q  <= addr_q;
               addr_q     <= addr_q + 32'd4;
               byte_idx_q <= '0;
               loading_q  <= 1'b0;
               if (full_word == TERMINATOR) begin
                  ld_state_q <= LD_RUN;
               end
            end else begin
               word_q[8*byte_idx_q +: 8] <= byte_q;
               byte_idx_q <= byte_idx_q + 2'd1;
               loading_q  <= 1'b1;
            end
         end
      end
   end

   assign write_byte_address = wr_addr_q;
   assign write_instr_data   = wr_data_q;
   assign write_instr_valid  = wr_valid_q;
   assign start              = start_q;
   assign loading            = loading_q;
   assign frame_error        = frame_error_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader at 4 clocks per UART bit.
module tb_instr_loader;

   localparam int unsigned CPB = 4;
   localparam int unsigned GAP = 6;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        uart_rx = 1'b1;
   logic [31:0] write_byte_address;
   logic [31:0] write_instr_data;
   logic        write_instr_valid;
   logic        start;
   logic        loading;
   logic        frame_error;

   int n_checks = 0;
   int n_errors = 0;

   int          cyc = 0;
   logic [31:0] s_addr[$];
   logic [31:0] s_data[$];
   int          s_cyc[$];
   int          start_cyc = -1;
   logic        start_prev = 1'b0;
   int          base;

   instr_loader #(.CLKS_PER_BIT(CPB)) dut (
      .clk                (clk),
      .rst                (rst),
      .uart_rx            (uart_rx),
      .write_byte_address (write_byte_address),
      .write_instr_data   (write_instr_data),
      .write_instr_valid  (write_instr_valid),
      .start              (start),
      .loading            (loading),
      .frame_error        (frame_error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Log every strobe and the cycle start first rises, sampled mid-cycle.
   always @(negedge clk) begin
      if (write_instr_valid) begin
         s_addr.push_back(write_byte_address);
         s_data.push_back(write_instr_data);
         s_cyc.push_back(cyc);
      end
      if (start && !start_prev) start_cyc = cyc;
      start_prev = start;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic drive_bit(input logic v);
      uart_rx = v;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_ok);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
      drive_bit(stop_ok);
      uart_rx = 1'b1;
      repeat (GAP) @(negedge clk);
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_addr",    write_byte_address, 32'h0);
      check("rst_data",    write_instr_data,   32'h0);
      check("rst_valid",   32'(write_instr_valid), 32'h0);
      check("rst_start",   32'(start),         32'h0);
      check("rst_loading", 32'(loading),       32'h0);
      check("rst_ferr",    32'(frame_error),   32'h0);

      // One-cycle low glitch on the line
      @(negedge clk);
      uart_rx = 1'b0;
      @(negedge clk);
      uart_rx = 1'b1;
      repeat (40) @(negedge clk);
      check("glitch_strobes", 32'(s_addr.size()), 32'd0);
      check("glitch_ferr",    32'(frame_error),   32'h0);
      check("glitch_loading", 32'(loading),       32'h0);

      // Single word 13 05 A0 00
      base = s_addr.size();
      send_byte(8'h13, 1'b1);
      check("w1_loading_b0", 32'(loading), 32'h1);
      send_byte(8'h05, 1'b1);
      send_byte(8'hA0, 1'b1);
      send_byte(8'h00, 1'b1);
      check("w1_strobes", 32'(s_addr.size() - base), 32'd1);
      if (s_addr.size() > base) begin
         check("w1_addr", s_addr[base], 32'h0);
         check("w1_data", s_data[base], 32'h00A00513);
      end
      check("w1_start",   32'(start),   32'h0);
      check("w1_loading", 32'(loading), 32'h0);
      check("w1_hold_data", write_instr_data, 32'h00A00513);
      check("w1_hold_valid", 32'(write_instr_valid), 32'h0);

      // Two words then the terminator
      do_reset();
      base = s_addr.size();
      send_word(32'h0000_0093);
      send_word(32'h1234_5678);
      send_word(32'hFFFF_FFFF);
      repeat (4) @(negedge clk);
      check("prog_strobes", 32'(s_addr.size() - base), 32'd3);
      if (s_addr.size() >= base + 3) begin
         check("prog_addr0", s_addr[base],   32'h0);
         check("prog_data0", s_data[base],   32'h0000_0093);
         check("prog_addr1", s_addr[base+1], 32'h4);
         check("prog_data1", s_data[base+1], 32'h1234_5678);
         check("prog_addr2", s_addr[base+2], 32'h8);
         check("prog_data2", s_data[base+2], 32'hFFFF_FFFF);
         check("prog_start_cycle", 32'(start_cyc), 32'(s_cyc[base+2] + 1));
      end
      check("prog_start", 32'(start), 32'h1);
      send_word(32'hDEAD_BEEF);
      check("run_no_strobe", 32'(s_addr.size() - base), 32'd3);
      check("run_start",     32'(start),            32'h1);
      check("run_hold_addr", write_byte_address,    32'h8);
      check("run_hold_data", write_instr_data,      32'hFFFF_FFFF);
      check("run_loading",   32'(loading),          32'h0);

      // Reset while running drops start on the next cycle
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("run_rst_start", 32'(start), 32'h0);
      rst = 1'b0;

      // Framing error between lanes 1 and 2
      do_reset();
      base = s_addr.size();
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      send_byte(8'h33, 1'b0);
      check("ferr_flag",    32'(frame_error),  32'h1);
      check("ferr_loading", 32'(loading),      32'h1);
      send_byte(8'h44, 1'b1);
      send_byte(8'h55, 1'b1);
      check("ferr_strobes", 32'(s_addr.size() - base), 32'd1);
      if (s_addr.size() > base) begin
         check("ferr_addr", s_addr[base], 32'h0);
         check("ferr_data", s_data[base], 32'h5544_2211);
      end
      check("ferr_sticky", 32'(frame_error), 32'h1);

      // Reset mid-word discards the partial word
      do_reset();
      check("mid_rst_ferr", 32'(frame_error), 32'h0);
      base = s_addr.size();
      send_byte(8'hAA, 1'b1);
      send_byte(8'hBB, 1'b1);
      check("mid_pre_loading", 32'(loading), 32'h1);
      do_reset();
      check("mid_rst_loading", 32'(loading), 32'h0);
      send_byte(8'h01, 1'b1);
      check("mid_loading1", 32'(loading), 32'h1);
      send_byte(8'h02, 1'b1);
      send_byte(8'h03, 1'b1);
      check("mid_loading3", 32'(loading), 32'h1);
      send_byte(8'h04, 1'b1);
      check("mid_loading4", 32'(loading), 32'h0);
      check("mid_strobes", 32'(s_addr.size() - base), 32'd1);
      if (s_addr.size() > base) begin
         check("mid_addr", s_addr[base], 32'h0);
         check("mid_data", s_data[base], 32'h0403_0201);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
